dice_roll_ctrl: RTL and testbench

Upstream controller for the dice counter. Takes the raw active-low push button (pin P35) and drives the dice counter's active-low `enable` input. It synchronises and debounces the button, then holds `enable` low every cycle while the button is held. On release it emits single-cycle `enable` pulses at exponentially growing intervals, so the displayed face visibly slows down and settles.

---
 rtl/dice_roll_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dice_roll_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl
// Front end for the dice counter: synchronises and debounces the raw
// active-low push button, holds the counter's active-low enable low while
// the button is held, and on release emits single-cycle enable pulses at
// doubling intervals so the displayed face slows down and settles.
//
// Ports
//   ck       in   system clock, rising edge
//   rst      in   asynchronous reset, active low
//   btn      in   raw button, active low, asynchronous to ck, may bounce
//   nEN      out  active-low count enable to the dice counter (registered)
//   rolling  out  high while rolling or slowing down (registered)
//   settled  out  one-cycle pulse when the slow-down completes (registered)
module dice_roll_ctrl #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned DEB_W      = 16,
    parameter int unsigned SLOW_BASE  = 4096,
    parameter int unsigned SLOW_STEPS = 8,
    parameter int unsigned GAP_W      = 24
) (
    input  logic ck,
    input  logic rst,
    input  logic btn,
    output logic nEN,
    output logic rolling,
    output logic settled
);

    localparam int unsigned STEP_W = $clog2(SLOW_STEPS + 1);

    localparam logic [DEB_W-1:0]  DEB_LIMIT = DEB_W'(DEB_CYCLES);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SLOW_STEPS);
    localparam logic [GAP_W-1:0]  GAP_FIRST = GAP_W'(SLOW_BASE - 1);
    localparam logic [GAP_W-1:0]  GAP_BASE  = GAP_W'(SLOW_BASE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        SLOW = 2'd2,
        DONE = 2'd3
    } state_t;

    // Synchroniser and debounce state
    logic             s1_q, s2_q;
    logic             db_q, db_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [DEB_W-1:0] deb_cnt_inc;

    // Roll / slow-down state
    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  gap_reload;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] step_inc;

    // Output registers
    logic nen_q, nen_d;
    logic rolling_q, rolling_d;
    logic settled_q, settled_d;

    // Two-flop synchroniser; resets to the released level
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= btn;
            s2_q <= s1_q;
        end
    end

    // Debounce: any cycle agreeing with db restarts the stability count
    always_comb begin
        db_d        = db_q;
        deb_cnt_d   = deb_cnt_q;
        deb_cnt_inc = deb_cnt_q + DEB_W'(1);
        if (s2_q == db_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_inc == DEB_LIMIT) begin
            db_d      = s2_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_inc;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            db_q      <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            db_q      <= db_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // FSM state register and output registers
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            step_q    <= '0;
            nen_q     <= 1'b1;
            rolling_q <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            step_q    <= step_d;
            nen_q     <= nen_d;
            rolling_q <= rolling_d;
            settled_q <= settled_d;
        end
    end

    // Next-state logic, then outputs decoded from the state being entered
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        step_d     = step_q;
        nen_d      = 1'b1;
        rolling_d  = 1'b0;
        settled_d  = 1'b0;
        step_inc   = step_q + STEP_W'(1);
        gap_reload = (GAP_BASE << step_inc) - GAP_W'(1);

        case (state_q)
            IDLE: begin
                if (!db_q) state_d = ROLL;
            end
            ROLL: begin
                if (db_q) begin
                    state_d = SLOW;
                    gap_d   = GAP_FIRST;
                    step_d  = '0;
                end
            end
            SLOW: begin
                // A re-press wins over a pulse due in the same cycle
                if (!db_q) begin
                    state_d = ROLL;
                    gap_d   = '0;
                    step_d  = '0;
                end else if (gap_q == '0) begin
                    step_d = step_inc;
                    if (step_inc == STEP_LAST) begin
                        state_d = DONE;
                    end else begin
                        gap_d = gap_reload;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            ROLL: begin
                nen_d     = 1'b0;
                rolling_d = 1'b1;
            end
            SLOW: begin
                // Pulse is registered, so it is decoded as gap reaches zero
                nen_d     = (gap_d != '0);
                rolling_d = 1'b1;
            end
            DONE: begin
                settled_d = 1'b1;
            end
            default: begin
                nen_d = 1'b1;
            end
        endcase
    end

    assign nEN     = nen_q;
    assign rolling = rolling_q;
    assign settled = settled_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Testbench for dice_roll_ctrl with DEB_CYCLES=4, SLOW_BASE=2, SLOW_STEPS=3.
// The stimulus process drives the button/reset once per cycle and queues the
// hand-derived output triple {nEN, rolling, settled} expected for that cycle;
// the monitor pops and compares on the falling edge.
module tb_dice_roll_ctrl;

    logic ck  = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic nEN;
    logic rolling;
    logic settled;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit done     = 1'b0;

    typedef struct {
        int         cyc;
        logic [2:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];

    dice_roll_ctrl #(
        .DEB_CYCLES (4),
        .DEB_W      (8),
        .SLOW_BASE  (2),
        .SLOW_STEPS (3),
        .GAP_W      (8)
    ) dut (
        .ck      (ck),
        .rst     (rst),
        .btn     (btn),
        .nEN     (nEN),
        .rolling (rolling),
        .settled (settled)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    // Monitor: one expected triple per cycle, checked mid-cycle
    always @(negedge ck) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks = n_checks + 1;
            if (e.cyc != cyc || {nEN, rolling, settled} !== e.exp) begin
                n_errors = n_errors + 1;
                $display("FAIL %s cyc=%0d (queued for %0d): nEN/rolling/settled got %b expected %b",
                         e.tag, cyc, e.cyc, {nEN, rolling, settled}, e.exp);
            end
        end
    end

    // Watchdog: the stimulus must complete within a bounded time
    initial begin
        #100000;
        if (!done) begin
            n_errors = n_errors + 1;
            $display("FAIL timeout: stimulus did not complete");
            $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
            $finish;
        end
    end

    // Drive one cycle of stimulus and queue the outputs expected in it
    task automatic tick(input logic b, input logic r, input logic en,
                        input logic ro, input logic se, input string tag);
        exp_t e;
        @(posedge ck);
        #1;
        btn   = b;
        rst   = r;
        e.cyc = cyc;
        e.exp = {en, ro, se};
        e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin
        // Reset held with the button wiggling, then 50 released idle cycles
        #2 rst = 1'b0;
        #1;
        n_checks = n_checks + 1;
        if ({nEN, rolling, settled} !== 3'b100) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_async: nEN/rolling/settled got %b expected 100",
                     {nEN, rolling, settled});
        end
        for (int i = 0; i < 6; i++)
            tick(logic'(i % 2), 1'b0, 1'b1, 1'b0, 1'b0, "reset_hold");
        for (int i = 0; i < 50; i++)
            tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "reset_idle");

        // Clean press, held, released at 21: T0=27, pulses 29/33/41, settle 42
        for (int i = 0; i <= 72; i++) begin
            logic b, en, ro, se;
            b  = (i >= 21);
            en = !((i >= 7 && i <= 27) || i == 29 || i == 33 || i == 41);
            ro = (i >= 7 && i <= 41);
            se = (i == 42);
            tick(b, 1'b1, en, ro, se, "press_slow_settle");
        end

        // Bounce: low runs of at most 3 cycles never reach the debounce count
        begin
            int   runs [20] = '{1,2,3,1,2,3,3,1,1,2,2,3,3,1,2,2,1,3,2,2};
            logic lvl;
            lvl = 1'b0;
            foreach (runs[k]) begin
                for (int j = 0; j < runs[k]; j++)
                    tick(lvl, 1'b1, 1'b1, 1'b0, 1'b0, "bounce_reject");
                lvl = ~lvl;
            end
            for (int i = 0; i < 12; i++)
                tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "bounce_settle");
        end

        // Press with a 3-cycle glitch at 15..17, release at 25 (T0=31),
        // re-press debounced at 37 (the T0+6 pulse), release at 50 (T0=56)
        for (int i = 0; i <= 100; i++) begin
            logic b, en, ro, se;
            b  = !((i < 15) || (i >= 18 && i < 25) || (i >= 31 && i < 50));
            en = !((i >= 7 && i <= 31) || i == 33 || (i >= 37 && i <= 56) ||
                   i == 58 || i == 62 || i == 70);
            ro = (i >= 7 && i <= 70);
            se = (i == 71);
            tick(b, 1'b1, en, ro, se, "glitch_repress");
        end

        // Release at 15 (T0=21), pulse at 23, reset asserted at T0+4 for 3 cycles
        for (int i = 0; i <= 60; i++) begin
            logic b, r, en, ro;
            b  = (i >= 15);
            r  = !(i >= 25 && i <= 27);
            en = !((i >= 7 && i <= 21) || i == 23);
            ro = (i >= 7 && i <= 24);
            tick(b, r, en, ro, 1'b0, "reset_mid_slow");
        end

        @(posedge ck);
        @(posedge ck);
        n_checks = n_checks + 1;
        if (sb.size() != 0) begin
            n_errors = n_errors + 1;
            $display("FAIL scoreboard: %0d expectations never compared", sb.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
